// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: next-PC select encoding
// and the branch-offset scaling shift.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    SEL_STEP = 3'd0,
    SEL_BR   = 3'd1,
    SEL_JMP  = 3'd2,
    SEL_CALL = 3'd3,
    SEL_RET  = 3'd4,
    SEL_HOLD = 3'd5
  } next_sel_e;

  // Branch offsets count instructions; shift converts them to a byte offset.
  localparam int unsigned BR_SHIFT = 2;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. A push when full overwrites the oldest entry;
// pop has priority over push and is ignored while empty.
module ras_stack
  import pc_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic [PW-1:0]    top_ptr_s;

  assign top_ptr_s = wr_ptr_r - PW'(1);
  assign top       = mem_r[top_ptr_s];
  assign empty     = (count_r == {CW{1'b0}});
  assign full      = (count_r == CW'(DEPTH));

  // Write pointer and occupancy; the pointer wraps so a full push drops the oldest entry.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (pop && !empty) begin
      wr_ptr_r <= wr_ptr_r - PW'(1);
      count_r  <= count_r - CW'(1);
    end else if (push && !pop) begin
      wr_ptr_r <= wr_ptr_r + PW'(1);
      if (!full) begin
        count_r <= count_r + CW'(1);
      end
    end
  end

  // Entry storage; contents are meaningless once the count is cleared.
  always_ff @(posedge Clk) begin
    if (!Rst && push && !pop) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: PC register with step/branch/jump/call/return select
// and an internal return-address stack. Optional macro PC_ALIGN_CHECK_EN adds the
// Misaligned output and rejects targets not aligned to STEP.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int unsigned      STEP      = 4,
  parameter logic [WIDTH-1:0] RESET_PC  = {WIDTH{1'b0}},
  parameter int               RAS_DEPTH = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Stall,
  input  logic             BranchTaken,
  input  logic [15:0]      BranchOffset,
  input  logic             Jump,
  input  logic             Call,
  input  logic             Ret,
  input  logic [WIDTH-1:0] JumpTarget,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PCPlusStep,
  output logic             RasEmpty,
  output logic             RasFull,
  output logic             RasErr
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic             Misaligned
`endif
);

  next_sel_e        sel_s;
  logic [WIDTH-1:0] pc_r;
  logic [WIDTH-1:0] pc_plus_step_s;
  logic [WIDTH-1:0] br_off_s;
  logic [WIDTH-1:0] br_target_s;
  logic [WIDTH-1:0] next_pc_s;
  logic [WIDTH-1:0] pc_d_s;
  logic [WIDTH-1:0] ras_top_s;
  logic             ras_empty_s;
  logic             ras_full_s;
  logic             push_s;
  logic             pop_s;
  logic             ras_err_s;
  logic             ras_err_r;
  logic             misalign_s;

  assign pc_plus_step_s = pc_r + WIDTH'(STEP);
  assign br_off_s       = WIDTH'($signed(BranchOffset)) << BR_SHIFT;
  assign br_target_s    = pc_plus_step_s + br_off_s;

  // Request priority: Stall > Ret > Call > Jump > BranchTaken > step.
  always_comb begin
    sel_s = SEL_STEP;
    if (Stall) begin
      sel_s = SEL_HOLD;
    end else if (Ret) begin
      sel_s = SEL_RET;
    end else if (Call) begin
      sel_s = SEL_CALL;
    end else if (Jump) begin
      sel_s = SEL_JMP;
    end else if (BranchTaken) begin
      sel_s = SEL_BR;
    end else begin
      sel_s = SEL_STEP;
    end
  end

  // Candidate next PC and the stack operation it implies.
  always_comb begin
    next_pc_s = pc_plus_step_s;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    ras_err_s = 1'b0;
    case (sel_s)
      SEL_HOLD: next_pc_s = pc_r;
      SEL_RET: begin
        if (ras_empty_s) begin
          ras_err_s = 1'b1;
        end else begin
          next_pc_s = ras_top_s;
          pop_s     = 1'b1;
        end
      end
      SEL_CALL: begin
        next_pc_s = JumpTarget;
        push_s    = 1'b1;
      end
      SEL_JMP:  next_pc_s = JumpTarget;
      SEL_BR:   next_pc_s = br_target_s;
      SEL_STEP: next_pc_s = pc_plus_step_s;
      default:  next_pc_s = pc_plus_step_s;
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  logic misaligned_r;

  // Only redirect targets are checked; a plain step (including Ret on empty) never is.
  always_comb begin
    misalign_s = 1'b0;
    if ((sel_s == SEL_JMP) || (sel_s == SEL_CALL) || (sel_s == SEL_BR) ||
        ((sel_s == SEL_RET) && !ras_empty_s)) begin
      misalign_s = ((next_pc_s & WIDTH'(STEP - 1)) != {WIDTH{1'b0}});
    end else begin
      misalign_s = 1'b0;
    end
  end

  // Misaligned pulse register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      misaligned_r <= 1'b0;
    end else begin
      misaligned_r <= misalign_s;
    end
  end

  assign Misaligned = misaligned_r;
`else
  assign misalign_s = 1'b0;
`endif

  assign pc_d_s = misalign_s ? pc_r : next_pc_s;

  // PC register and return-on-empty error pulse.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc_r      <= RESET_PC;
      ras_err_r <= 1'b0;
    end else begin
      pc_r      <= pc_d_s;
      ras_err_r <= ras_err_s;
    end
  end

  ras_stack #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .Clk       (Clk),
    .Rst       (Rst),
    .push      (push_s && !misalign_s),
    .pop       (pop_s && !misalign_s),
    .push_data (pc_plus_step_s),
    .top       (ras_top_s),
    .empty     (ras_empty_s),
    .full      (ras_full_s)
  );

  assign PC         = pc_r;
  assign PCPlusStep = pc_plus_step_s;
  assign RasEmpty   = ras_empty_s;
  assign RasFull    = ras_full_s;
  assign RasErr     = ras_err_r;

endmodule
